// File: rtl/receiver.sv
// UART 8N1 receiver: two-flop synchronised serial input, mid-bit sampling timed by a
// bit-period counter, registered one-cycle data-valid and framing-error pulses.
module receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [1:0]       sync_r;
    logic             rxd_s;
    logic             rxd_prev_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;

    assign rxd_s = sync_r[1];

    // Two-flop synchroniser for the asynchronous serial line; idles high out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rxd};
        end
    end

    // Receive FSM: the counter is cleared on every accepted sample so each later
    // sample lands one full bit period after the previous one, i.e. at mid-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            rxd_prev_r <= 1'b1;
            cnt_r      <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_busy    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rxd_prev_r <= rxd_s;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Edge-triggered start so a line stuck low cannot retrigger.
                    if (rxd_prev_r && !rxd_s) begin
                        state_r   <= START;
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                        rx_busy   <= 1'b1;
                    end else begin
                        cnt_r <= '0;
                    end
                end
                START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= '0;
                        if (!rxd_s) begin
                            state_r <= DATA;
                        end else begin
                            state_r <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r   <= '0;
                        shift_r <= {rxd_s, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r   <= '0;
                        state_r <= IDLE;
                        rx_busy <= 1'b0;
                        if (rxd_s) begin
                            rx_data  <= shift_r;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: table-driven frames, hand-written corner sequences,
// and randomised frames checked against a frame-level reference model.
module tb_receiver;
    localparam int CPB = 16;
    // rxd driven low in cycle s -> rxd_s low at T = s+2; stop sampled at T+CPB/2+9*CPB,
    // pulse one cycle later.
    localparam int PULSE_LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  act_q[$];
    ev_t  exp_q[$];
    int   rise_q[$];
    int   fall_q[$];
    int   exp_rise_q[$];
    int   exp_fall_q[$];
    logic [7:0] prev_data = 8'h00;
    logic       prev_busy = 1'b0;
    logic [7:0] model_data = 8'h00;
    vec_t tbl[8];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs pulses and busy edges, checks the always-true output rules.
    always @(negedge clk) begin
        if (rx_valid || frame_err) begin
            act_q.push_back('{cyc, frame_err, rx_data});
            n_cmp++;
            if (rx_valid && frame_err) begin
                n_bad++;
                $display("FAIL excl_pulse cyc=%0d: rx_valid=1 frame_err=1, required not both", cyc);
            end
        end
        if (rst && rx_data !== prev_data) begin
            n_cmp++;
            if (rx_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL data_hold cyc=%0d: rx_data %h -> %h without rx_valid", cyc, prev_data, rx_data);
            end
        end
        if (rx_busy && !prev_busy) rise_q.push_back(cyc);
        if (!rx_busy && prev_busy) fall_q.push_back(cyc);
        prev_data <= rx_data;
        prev_busy <= rx_busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        act_q.delete(); exp_q.delete();
        rise_q.delete(); fall_q.delete();
        exp_rise_q.delete(); exp_fall_q.delete();
    endtask

    task automatic compare_all(input string tag);
        check({tag, " event_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check({tag, " event_cycle"}, act_q[i].cyc, exp_q[i].cyc);
            check({tag, " event_is_err"}, 32'(act_q[i].is_err), 32'(exp_q[i].is_err));
            check({tag, " event_rx_data"}, 32'(act_q[i].data), 32'(exp_q[i].data));
        end
        check({tag, " busy_rise_count"}, rise_q.size(), exp_rise_q.size());
        for (int i = 0; i < exp_rise_q.size() && i < rise_q.size(); i++)
            check({tag, " busy_rise_cycle"}, rise_q[i], exp_rise_q[i]);
        check({tag, " busy_fall_count"}, fall_q.size(), exp_fall_q.size());
        for (int i = 0; i < exp_fall_q.size() && i < fall_q.size(); i++)
            check({tag, " busy_fall_cycle"}, fall_q[i], exp_fall_q[i]);
        clear_q();
    endtask

    // Reference model: a well-framed byte becomes rx_data, a bad stop bit keeps the old value.
    task automatic expect_frame(input int s, input logic [7:0] d, input logic stop);
        if (stop) model_data = d;
        exp_q.push_back('{s + PULSE_LAT, !stop, model_data});
        exp_rise_q.push_back(s + 3);
        exp_fall_q.push_back(s + PULSE_LAT);
    endtask

    // Drives one 10-bit frame starting at the current phase; returns the start cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int phase, output int s);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        s = cyc;
        for (int b = 0; b < 10; b++) begin
            rxd = bits[b];
            repeat (CPB) @(posedge clk);
            #phase;
        end
    endtask

    initial begin
        int s;
        int phase;
        int gap;
        logic [7:0] d;
        logic stop;
        logic prev_stop;
        logic [9:0] bits;

        tbl[0] = '{8'h12, 1'b1, 0, 1'b0, 8'h12};
        tbl[1] = '{8'h34, 1'b1, 0, 1'b0, 8'h34};
        tbl[2] = '{8'h87, 1'b1, 4, 1'b0, 8'h87};
        tbl[3] = '{8'hA5, 1'b0, 3, 1'b1, 8'h87};
        tbl[4] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF};
        tbl[5] = '{8'h00, 1'b1, 7, 1'b0, 8'h00};
        tbl[6] = '{8'h80, 1'b1, 1, 1'b0, 8'h80};
        tbl[7] = '{8'h01, 1'b1, 5, 1'b0, 8'h01};

        // Reset values
        repeat (3) @(negedge clk);
        check("reset rx_data", 32'(rx_data), 32'h00);
        check("reset rx_valid", 32'(rx_valid), 32'h0);
        check("reset rx_busy", 32'(rx_busy), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        @(posedge clk); #3;
        rst = 1'b1;
        repeat (4) @(posedge clk); #3;
        clear_q();

        // Table-driven frames, including back-to-back and a bad stop bit
        phase = 3;
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, phase, s);
            exp_q.push_back('{s + PULSE_LAT, tbl[i].exp_err, tbl[i].exp_data});
            exp_rise_q.push_back(s + 3);
            exp_fall_q.push_back(s + PULSE_LAT);
            if (tbl[i].gap > 0) begin
                rxd = 1'b1;
                repeat (tbl[i].gap) @(posedge clk);
                #phase;
            end
        end
        model_data = tbl[7].exp_data;
        rxd = 1'b1;
        repeat (200) @(posedge clk); #3;
        compare_all("table");

        // Short glitch: rejected at the half-bit sample, busy high for CPB/2 cycles
        s = cyc;
        rxd = 1'b0;
        repeat (5) @(posedge clk); #3;
        rxd = 1'b1;
        exp_rise_q.push_back(s + 3);
        exp_fall_q.push_back(s + 3 + CPB / 2);
        repeat (60) @(posedge clk); #3;
        compare_all("glitch");

        // Good frame, bad stop bit, then line held low: no retrigger until a new falling edge
        send_frame(8'h12, 1'b1, 3, s);
        expect_frame(s, 8'h12, 1'b1);
        send_frame(8'hA5, 1'b0, 3, s);
        expect_frame(s, 8'hA5, 1'b0);
        repeat (80) @(posedge clk); #3;
        check("stuck_low rx_busy", 32'(rx_busy), 32'h0);
        check("stuck_low rx_data", 32'(rx_data), 32'h12);
        rxd = 1'b1;
        repeat (20) @(posedge clk); #3;
        send_frame(8'h5A, 1'b1, 3, s);
        expect_frame(s, 8'h5A, 1'b1);
        repeat (200) @(posedge clk); #3;
        compare_all("stop_err");

        // Randomised frames with random gaps and random sub-cycle phase of rxd
        prev_stop = 1'b1;
        for (int i = 0; i < 24; i++) begin
            d = (i == 0) ? 8'hFF : (i == 1) ? 8'h00 : 8'($urandom_range(0, 255));
            stop = (i < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 12);
            if (i == 0 || (!prev_stop && gap < 2)) gap = 2;
            if (gap > 0) begin
                rxd = 1'b1;
                repeat (gap) @(posedge clk);
                phase = $urandom_range(1, 9);
                #phase;
            end
            send_frame(d, stop, phase, s);
            expect_frame(s, d, stop);
            prev_stop = stop;
        end
        rxd = 1'b1;
        repeat (200) @(posedge clk); #3;
        compare_all("random");

        // Reset asserted during data bit 4 of 0x55, then a clean 0x3C
        bits = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 5; b++) begin
            rxd = bits[b];
            repeat (CPB) @(posedge clk); #3;
        end
        rxd = bits[5];
        repeat (CPB / 2) @(posedge clk); #3;
        check("pre_reset rx_busy", 32'(rx_busy), 32'h1);
        rst = 1'b0;
        #1;
        check("async_reset rx_busy", 32'(rx_busy), 32'h0);
        @(negedge clk);
        check("midframe_reset rx_data", 32'(rx_data), 32'h00);
        check("midframe_reset rx_valid", 32'(rx_valid), 32'h0);
        check("midframe_reset frame_err", 32'(frame_err), 32'h0);
        repeat (3) @(posedge clk); #3;
        rst = 1'b1;
        clear_q();
        model_data = 8'h00;
        repeat (30) @(posedge clk); #3;
        send_frame(8'h3C, 1'b1, 3, s);
        expect_frame(s, 8'h3C, 1'b1);
        repeat (200) @(posedge clk); #3;
        compare_all("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
